// File: rtl/acq_sequencer.sv
// Acquisition session sequencer: aligns DAC playback start with ADC capture gating,
// flags overrun/underrun and counts captured frames. Single clock, synchronous reset.
module acq_sequencer #(
    parameter int unsigned PRIME_FRAMES = 4,
    parameter int unsigned CNT_W        = 32,
    parameter bit          FREE_RUN     = 1'b1
) (
    input  logic             capture_clk,
    input  logic             rst,
    input  logic             adc_open,
    input  logic             dac_open,
    input  logic             dac_empty,
    input  logic             capture_full,
    input  logic             frame_tick,
    output logic             dac_run,
    output logic             capture_gate,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       underruns,
    output logic             overrun
);

    // A zero-frame prime still needs a legal 1-bit counter.
    localparam int unsigned PW = (PRIME_FRAMES > 0) ? $clog2(PRIME_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_PRIME   = 3'd2,
        S_RUN     = 3'd3,
        S_OVERRUN = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              dac_run_q, dac_run_d;
    logic              gate_q, gate_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic [7:0]        underruns_q, underruns_d;
    logic              overrun_q, overrun_d;
    logic [PW-1:0]     prime_cnt_q, prime_cnt_d;

    // State and status registers.
    always_ff @(posedge capture_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dac_run_q     <= 1'b0;
            gate_q        <= 1'b0;
            frame_count_q <= '0;
            underruns_q   <= '0;
            overrun_q     <= 1'b0;
            prime_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            dac_run_q     <= dac_run_d;
            gate_q        <= gate_d;
            frame_count_q <= frame_count_d;
            underruns_q   <= underruns_d;
            overrun_q     <= overrun_d;
            prime_cnt_q   <= prime_cnt_d;
        end
    end

    // Next-state, gate and counter logic; closing the ADC reader aborts from anywhere.
    always_comb begin
        state_d       = state_q;
        dac_run_d     = dac_run_q;
        gate_d        = gate_q;
        frame_count_d = frame_count_q;
        underruns_d   = underruns_q;
        overrun_d     = overrun_q;
        prime_cnt_d   = prime_cnt_q;

        if (!adc_open) begin
            state_d     = S_IDLE;
            dac_run_d   = 1'b0;
            gate_d      = 1'b0;
            prime_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dac_run_d   = 1'b0;
                    gate_d      = 1'b0;
                    prime_cnt_d = '0;
                    if (dac_open || FREE_RUN) begin
                        frame_count_d = '0;
                        underruns_d   = '0;
                        overrun_d     = 1'b0;
                        if (dac_open) begin
                            state_d = S_ARMED;
                        end else begin
                            state_d = S_RUN;
                            gate_d  = 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    dac_run_d = 1'b0;
                    gate_d    = 1'b0;
                    if (!dac_open) begin
                        state_d = S_IDLE;
                    end else if (frame_tick && !dac_empty) begin
                        dac_run_d = 1'b1;
                        if (PRIME_FRAMES == 0) begin
                            state_d = S_RUN;
                            gate_d  = 1'b1;
                        end else begin
                            state_d     = S_PRIME;
                            prime_cnt_d = PW'(PRIME_FRAMES);
                        end
                    end
                end
                S_PRIME: begin
                    dac_run_d = 1'b1;
                    gate_d    = 1'b0;
                    if (!dac_open) begin
                        state_d   = S_IDLE;
                        dac_run_d = 1'b0;
                    end else if (frame_tick) begin
                        prime_cnt_d = prime_cnt_q - PW'(1);
                        if (prime_cnt_q <= PW'(1)) begin
                            state_d = S_RUN;
                            gate_d  = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    gate_d    = 1'b1;
                    dac_run_d = dac_run_q && dac_open;
                    if (frame_tick) begin
                        frame_count_d = frame_count_q + CNT_W'(1);
                        if (dac_run_q && dac_empty && (underruns_q != 8'hFF)) begin
                            underruns_d = underruns_q + 8'd1;
                        end
                    end
                    if (capture_full) begin
                        state_d   = S_OVERRUN;
                        overrun_d = 1'b1;
                        gate_d    = 1'b0;
                    end
                end
                S_OVERRUN: begin
                    gate_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    dac_run_d = 1'b0;
                    gate_d    = 1'b0;
                end
            endcase
        end
    end

    assign dac_run      = dac_run_q;
    assign capture_gate = gate_q;
    assign state        = state_q;
    assign frame_count  = frame_count_q;
    assign underruns    = underruns_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: expected snapshots are queued as stimulus is
// driven and compared one cycle later. A second instance covers FREE_RUN=0 and
// a zero-frame prime.
module tb_acq_sequencer;

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [2:0]       st;
        logic             dr;
        logic             cg;
        logic [CNT_W-1:0] fc;
        logic [7:0]       ur;
        logic             ov;
    } snap_t;

    logic             capture_clk = 1'b0;
    logic             rst = 1'b0;
    logic             adc_open = 1'b0;
    logic             dac_open = 1'b0;
    logic             dac_empty = 1'b0;
    logic             capture_full = 1'b0;
    logic             frame_tick = 1'b0;
    logic             dac_run, capture_gate, overrun;
    logic [2:0]       state;
    logic [CNT_W-1:0] frame_count;
    logic [7:0]       underruns;

    logic             nf_dac_run, nf_capture_gate, nf_overrun;
    logic [2:0]       nf_state;
    logic [CNT_W-1:0] nf_frame_count;
    logic [7:0]       nf_underruns;

    snap_t            exp_q[$];
    snap_t            got, e;
    int               n_checks = 0;
    int               n_fail = 0;
    int unsigned      exp_fc = 0;
    int unsigned      exp_ur = 0;

    acq_sequencer #(.PRIME_FRAMES(4), .CNT_W(CNT_W), .FREE_RUN(1'b1)) dut (
        .capture_clk(capture_clk), .rst(rst), .adc_open(adc_open), .dac_open(dac_open),
        .dac_empty(dac_empty), .capture_full(capture_full), .frame_tick(frame_tick),
        .dac_run(dac_run), .capture_gate(capture_gate), .state(state),
        .frame_count(frame_count), .underruns(underruns), .overrun(overrun)
    );

    acq_sequencer #(.PRIME_FRAMES(0), .CNT_W(CNT_W), .FREE_RUN(1'b0)) dut_nf (
        .capture_clk(capture_clk), .rst(rst), .adc_open(adc_open), .dac_open(dac_open),
        .dac_empty(dac_empty), .capture_full(capture_full), .frame_tick(frame_tick),
        .dac_run(nf_dac_run), .capture_gate(nf_capture_gate), .state(nf_state),
        .frame_count(nf_frame_count), .underruns(nf_underruns), .overrun(nf_overrun)
    );

    always #5 capture_clk = ~capture_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic snap_t snap();
        snap_t s;
        s.st = state;
        s.dr = dac_run;
        s.cg = capture_gate;
        s.fc = frame_count;
        s.ur = underruns;
        s.ov = overrun;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d dr=%0b cg=%0b fc=%0d ur=%0d ov=%0b",
                         s.st, s.dr, s.cg, s.fc, s.ur, s.ov);
    endfunction

    function automatic void push_exp(int st, bit dr, bit cg, int unsigned fc, int unsigned ur, bit ov);
        snap_t s;
        s.st = 3'(st);
        s.dr = dr;
        s.cg = cg;
        s.fc = CNT_W'(fc);
        s.ur = 8'(ur);
        s.ov = ov;
        exp_q.push_back(s);
    endfunction

    task automatic step();
        @(negedge capture_clk);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge capture_clk);
    endtask

    task automatic tick_only();
        frame_tick = 1'b1;
        @(negedge capture_clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adc_open = 1'b1; dac_open = 1'b1; dac_empty = 1'b1;
        capture_full = 1'b1; frame_tick = 1'b1;
        push_exp(0, 0, 0, 0, 0, 0);
        idle(2);
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL reset: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b0; dac_open = 1'b0; dac_empty = 1'b0;
        capture_full = 1'b0; frame_tick = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_normal_start();
        adc_open = 1'b1; dac_open = 1'b1; dac_empty = 1'b0;
        push_exp(1, 0, 0, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL armed: got %s want %s", fmt(got), fmt(e));
        end
        idle(10);
        push_exp(1, 0, 0, 0, 0, 0);
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL armed_hold: got %s want %s", fmt(got), fmt(e));
        end
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) push_exp(2, 1, 0, 0, 0, 0);
            else       push_exp(3, 1, 1, 0, 0, 0);
            tick_only();
            got = snap(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL prime_tick%0d: got %s want %s", k, fmt(got), fmt(e));
            end
            if (k == 1) begin
                n_checks++;
                if (nf_state !== 3'd3 || nf_capture_gate !== 1'b1 || nf_dac_run !== 1'b1) begin
                    n_fail++;
                    $display("FAIL zero_prime: got st=%0d cg=%0b dr=%0b want st=3 cg=1 dr=1",
                             nf_state, nf_capture_gate, nf_dac_run);
                end
            end
            idle(31);
        end
        exp_fc = 0;
        for (int k = 1; k <= 10; k++) begin
            exp_fc++;
            push_exp(3, 1, 1, exp_fc, 0, 0);
            tick_only();
            got = snap(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL run_count%0d: got %s want %s", k, fmt(got), fmt(e));
            end
            idle(31);
        end
    endtask

    task automatic test_underrun();
        dac_empty = 1'b1;
        exp_ur = 0;
        for (int i = 1; i <= 300; i++) begin
            exp_fc++;
            if (exp_ur < 255) exp_ur++;
            push_exp(3, 1, 1, exp_fc, exp_ur, 0);
            tick_only();
            got = snap(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL underrun%0d: got %s want %s", i, fmt(got), fmt(e));
            end
            idle(31);
        end
        dac_empty = 1'b0;
    endtask

    task automatic test_overrun();
        exp_fc++;
        push_exp(4, 1, 0, exp_fc, exp_ur, 1);
        frame_tick = 1'b1; capture_full = 1'b1;
        step();
        frame_tick = 1'b0; capture_full = 1'b0;
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL overrun_entry: got %s want %s", fmt(got), fmt(e));
        end
        push_exp(4, 1, 0, exp_fc, exp_ur, 1);
        tick_only();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL overrun_frozen: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b0;
        push_exp(0, 0, 0, exp_fc, exp_ur, 1);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL overrun_close: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b1;
        exp_fc = 0; exp_ur = 0;
        push_exp(1, 0, 0, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL overrun_reopen: got %s want %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_free_run();
        adc_open = 1'b0; dac_open = 1'b0;
        push_exp(0, 0, 0, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL free_idle: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b1;
        push_exp(3, 0, 1, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL free_start: got %s want %s", fmt(got), fmt(e));
        end
        dac_empty = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push_exp(3, 0, 1, k, 0, 0);
            tick_only();
            got = snap(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL free_count%0d: got %s want %s", k, fmt(got), fmt(e));
            end
            n_checks++;
            if (nf_state !== 3'd0 || nf_capture_gate !== 1'b0) begin
                n_fail++;
                $display("FAIL no_free_run%0d: got st=%0d cg=%0b want st=0 cg=0",
                         k, nf_state, nf_capture_gate);
            end
            idle(7);
        end
        dac_empty = 1'b0;
    endtask

    task automatic test_abort();
        adc_open = 1'b0;
        step();
        adc_open = 1'b1; dac_open = 1'b1;
        push_exp(1, 0, 0, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL abort_armed: got %s want %s", fmt(got), fmt(e));
        end
        for (int k = 0; k < 2; k++) begin
            push_exp(2, 1, 0, 0, 0, 0);
            tick_only();
            got = snap(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL abort_prime%0d: got %s want %s", k, fmt(got), fmt(e));
            end
            idle(3);
        end
        adc_open = 1'b0;
        push_exp(0, 0, 0, 0, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL abort_from_prime: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            tick_only();
            idle(3);
        end
        push_exp(3, 1, 1, 1, 0, 0);
        tick_only();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL abort_run: got %s want %s", fmt(got), fmt(e));
        end
        dac_open = 1'b0;
        push_exp(3, 0, 1, 1, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL dac_drop: got %s want %s", fmt(got), fmt(e));
        end
        dac_open = 1'b1;
        push_exp(3, 0, 1, 1, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL dac_reopen: got %s want %s", fmt(got), fmt(e));
        end
        adc_open = 1'b0;
        push_exp(0, 0, 0, 1, 0, 0);
        step();
        got = snap(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) begin
            n_fail++; $display("FAIL abort_from_run: got %s want %s", fmt(got), fmt(e));
        end
    endtask

    initial begin
        @(negedge capture_clk);
        test_reset();
        test_normal_start();
        test_underrun();
        test_overrun();
        test_free_run();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
